// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Brief    : Shared widths, constants and state encoding for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    localparam int c_INST_ADDR_W = 32;
    localparam int c_INST_W      = 32;

    localparam logic [c_INST_W-1:0] c_ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKID = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_skid.sv
`default_nettype none
// ============================================================================
// Module   : if_skid
// Brief    : One-entry pc/inst holding buffer; clear wins over load.
// Revision : 1.0 - initial release
// ============================================================================
module if_skid
    import if_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_clear,
    input  logic [c_INST_ADDR_W-1:0] i_pc,
    input  logic [c_INST_W-1:0]      i_inst,
    output logic [c_INST_ADDR_W-1:0] o_pc,
    output logic [c_INST_W-1:0]      o_inst
);

    logic [c_INST_ADDR_W-1:0] r_pc;
    logic [c_INST_W-1:0]      r_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= c_ZERO_WORD;
            r_inst <= c_ZERO_WORD;
        end else if (i_clear) begin
            r_pc   <= c_ZERO_WORD;
            r_inst <= c_ZERO_WORD;
        end else if (i_load) begin
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end
    end

    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : Instruction fetch stage with req/ack memory port, skid buffer and
//            redirect handling. Optional misaligned-fetch trap: IF_MISALIGN_EXC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [c_INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [c_INST_ADDR_W-1:0] redirect_pc,
    output logic                     imem_req,
    output logic [c_INST_ADDR_W-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [c_INST_W-1:0]      imem_rdata,
    output logic [c_INST_ADDR_W-1:0] if_pc,
    output logic [c_INST_W-1:0]      if_inst,
    output logic                     if_valid,
    output logic                     if_exc
);

    fetch_state_e             r_state, w_state_nxt;
    logic [c_INST_ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [c_INST_ADDR_W-1:0] r_pend_pc, w_pend_nxt;
    logic [c_INST_ADDR_W-1:0] r_out_pc, w_out_pc_nxt;
    logic [c_INST_W-1:0]      r_out_inst, w_out_inst_nxt;
    logic                     r_out_valid, w_out_valid_nxt;
    logic                     r_out_exc, w_out_exc_nxt;
    logic                     w_misalign, w_req, w_ack;
    logic                     w_sk_load, w_sk_clear;
    logic [c_INST_ADDR_W-1:0] w_sk_pc;
    logic [c_INST_W-1:0]      w_sk_inst;

`ifdef IF_MISALIGN_EXC_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // DROP keeps the abandoned request alive until memory acknowledges it.
    assign w_req     = ((r_state == ST_RUN) && !w_misalign) || (r_state == ST_DROP);
    assign w_ack     = imem_ack && w_req;
    assign imem_req  = w_req && rst;
    assign imem_addr = {r_pc[c_INST_ADDR_W-1:2], 2'b00};

    assign if_pc    = r_out_pc;
    assign if_inst  = r_out_inst;
    assign if_valid = r_out_valid;
    assign if_exc   = r_out_exc;

    if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_sk_load),
        .i_clear (w_sk_clear),
        .i_pc    (r_pc),
        .i_inst  (imem_rdata),
        .o_pc    (w_sk_pc),
        .o_inst  (w_sk_inst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_pend_pc   <= RESET_PC;
            r_out_pc    <= c_ZERO_WORD;
            r_out_inst  <= c_ZERO_WORD;
            r_out_valid <= 1'b0;
            r_out_exc   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_pc   <= w_pend_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_inst  <= w_out_inst_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_exc   <= w_out_exc_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_nxt      = r_pend_pc;
        w_out_pc_nxt    = r_out_pc;
        w_out_inst_nxt  = r_out_inst;
        w_out_valid_nxt = r_out_valid;
        w_out_exc_nxt   = r_out_exc;
        w_sk_load       = 1'b0;
        w_sk_clear      = 1'b0;

        if (flush_i) begin
            w_out_valid_nxt = 1'b0;
            w_out_exc_nxt   = 1'b0;
            w_sk_clear      = 1'b0 | 1'b1;
            w_pend_nxt      = redirect_pc;
            if (w_req && !w_ack) begin
                w_state_nxt = ST_DROP;
            end else begin
                w_pc_nxt    = redirect_pc;
                w_state_nxt = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_misalign) begin
                        if (!stall_i) begin
                            w_out_pc_nxt    = r_pc;
                            w_out_inst_nxt  = c_ZERO_WORD;
                            w_out_valid_nxt = 1'b1;
                            w_out_exc_nxt   = 1'b1;
                            w_state_nxt     = ST_HALT;
                        end
                    end else if (w_ack) begin
                        w_pc_nxt = r_pc + 32'd4;
                        if (stall_i) begin
                            w_sk_load   = 1'b1;
                            w_state_nxt = ST_SKID;
                        end else begin
                            w_out_pc_nxt    = r_pc;
                            w_out_inst_nxt  = imem_rdata;
                            w_out_valid_nxt = 1'b1;
                            w_out_exc_nxt   = 1'b0;
                        end
                    end else if (!stall_i) begin
                        w_out_valid_nxt = 1'b0;
                    end
                end
                ST_SKID: begin
                    if (!stall_i) begin
                        w_out_pc_nxt    = w_sk_pc;
                        w_out_inst_nxt  = w_sk_inst;
                        w_out_valid_nxt = 1'b1;
                        w_out_exc_nxt   = 1'b0;
                        w_sk_clear      = 1'b1;
                        w_state_nxt     = ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (w_ack) begin
                        w_pc_nxt    = r_pend_pc;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    // HALT: parked on a misaligned target until redirected
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Self-checking bench for if_fetch against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_exc;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .if_exc      (if_exc)
    );

    int checks   = 0;
    int failures = 0;

    // Model: next fetch address, an accepted-but-unpresented instruction,
    // and whether the outstanding request belongs to an abandoned path.
    logic [31:0] m_pc    = c_RESET_PC;
    logic [31:0] m_pend  = c_RESET_PC;
    logic [31:0] m_opc   = 32'h0;
    logic [31:0] m_oinst = 32'h0;
    logic [31:0] m_hpc   = 32'h0;
    logic [31:0] m_hinst = 32'h0;
    bit          m_valid = 1'b0;
    bit          m_exc   = 1'b0;
    bit          m_held  = 1'b0;
    bit          m_halt  = 1'b0;
    bit          m_wrong = 1'b0;
    bit          m_req   = 1'b1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_mis();
`ifdef IF_MISALIGN_EXC_EN
        return (m_pc[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_edge();
        bit ak;
        ak = imem_ack && m_req;
        if (flush_i) begin
            m_valid = 1'b0;
            m_exc   = 1'b0;
            m_held  = 1'b0;
            m_halt  = 1'b0;
            if (m_req && !ak) begin
                m_wrong = 1'b1;
                m_pend  = redirect_pc;
            end else begin
                m_wrong = 1'b0;
                m_pc    = redirect_pc;
            end
        end else if (m_held) begin
            if (!stall_i) begin
                m_opc   = m_hpc;
                m_oinst = m_hinst;
                m_valid = 1'b1;
                m_exc   = 1'b0;
                m_held  = 1'b0;
            end
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (model_mis()) begin
            if (!stall_i) begin
                m_opc   = m_pc;
                m_oinst = 32'h0;
                m_valid = 1'b1;
                m_exc   = 1'b1;
                m_halt  = 1'b1;
            end
        end else if (ak) begin
            if (m_wrong) begin
                m_wrong = 1'b0;
                m_pc    = m_pend;
            end else begin
                if (stall_i) begin
                    m_held  = 1'b1;
                    m_hpc   = m_pc;
                    m_hinst = mem_data({m_pc[31:2], 2'b00});
                end else begin
                    m_opc   = m_pc;
                    m_oinst = mem_data({m_pc[31:2], 2'b00});
                    m_valid = 1'b1;
                    m_exc   = 1'b0;
                end
                m_pc = m_pc + 32'd4;
            end
        end else if (!stall_i) begin
            m_valid = 1'b0;
        end
        m_req = m_wrong || (!m_held && !m_halt && !model_mis());
    endtask

    task automatic step(input bit st, input bit fl, input logic [31:0] rp, input bit ak);
        stall_i     = st;
        flush_i     = fl;
        redirect_pc = rp;
        imem_ack    = ak;
        imem_rdata  = mem_data(imem_addr);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Per-cycle comparison against the model plus the request-hold property.
    bit          hold_pend = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    always @(negedge clk) begin
        chkb("imem_req", imem_req, m_req && rst);
        if (m_req && rst) chk("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
        chkb("if_valid", if_valid, m_valid);
        chkb("if_exc", if_exc, m_exc);
        if (m_valid) begin
            chk("if_pc", if_pc, m_opc);
            chk("if_inst", if_inst, m_oinst);
        end
        if (hold_pend) begin
            chkb("hs_req_stable", imem_req, 1'b1);
            chk("hs_addr_stable", imem_addr, hold_addr);
        end
        hold_pend = imem_req && !imem_ack;
        hold_addr = imem_addr;
    end

    initial begin
        int mode;
        bit ak;
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", if_valid, 1'b0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chkb("rst_exc", if_exc, 1'b0);
        rst = 1'b1;
        #1;
        chkb("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h100);

        // Zero-wait memory
        step(0, 0, 32'h0, 1);
        chkb("zw_valid", if_valid, 1'b1);
        chk("zw_pc0", if_pc, 32'h100);
        chk("zw_inst0", if_inst, mem_data(32'h100));
        chk("zw_addr1", imem_addr, 32'h104);
        step(0, 0, 32'h0, 1);
        chk("zw_addr2", imem_addr, 32'h108);
        chk("zw_pc1", if_pc, 32'h104);

        // Three stall cycles starting with the ack of 0x108
        step(1, 0, 32'h0, 1);
        chk("stall_hold_pc", if_pc, 32'h104);
        chkb("skid_noreq", imem_req, 1'b0);
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        chk("stall_hold_pc3", if_pc, 32'h104);
        chkb("stall_hold_valid", if_valid, 1'b1);
        step(0, 0, 32'h0, 0);
        chk("skid_pc", if_pc, 32'h108);
        chk("skid_inst", if_inst, mem_data(32'h108));
        chk("resume_addr", imem_addr, 32'h10C);

        // Redirect while 0x10C is outstanding
        step(0, 1, 32'h200, 0);
        chkb("drop_valid", if_valid, 1'b0);
        chkb("drop_req", imem_req, 1'b1);
        chk("drop_addr", imem_addr, 32'h10C);
        step(0, 0, 32'h0, 1);
        chkb("drop_discard", if_valid, 1'b0);
        chk("redir_addr", imem_addr, 32'h200);
        step(0, 0, 32'h0, 1);
        chkb("redir_valid", if_valid, 1'b1);
        chk("redir_pc", if_pc, 32'h200);

        // Flush and stall together while the skid holds 0x204
        step(1, 0, 32'h0, 1);
        step(1, 1, 32'h300, 0);
        chkb("fs_valid", if_valid, 1'b0);
        chkb("fs_req", imem_req, 1'b1);
        chk("fs_addr", imem_addr, 32'h300);
        step(0, 0, 32'h0, 0);
        chkb("lat_bubble", if_valid, 1'b0);
        chk("lat_addr", imem_addr, 32'h300);
        step(0, 0, 32'h0, 1);
        chkb("lat_valid", if_valid, 1'b1);
        chk("lat_pc", if_pc, 32'h300);

`ifdef IF_MISALIGN_EXC_EN
        step(0, 1, 32'h202, 1);
        chkb("mis_noreq", imem_req, 1'b0);
        step(0, 0, 32'h0, 0);
        chkb("mis_valid", if_valid, 1'b1);
        chkb("mis_exc", if_exc, 1'b1);
        chk("mis_pc", if_pc, 32'h202);
        chk("mis_inst", if_inst, 32'h0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        chkb("halt_noreq", imem_req, 1'b0);
        step(0, 1, 32'h300, 0);
        chkb("halt_resume_req", imem_req, 1'b1);
        chk("halt_resume_addr", imem_addr, 32'h300);
`endif

        // Randomized traffic across several memory latency profiles
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 250) % 4;
            case (mode)
                0:       ak = 1'b1;
                1:       ak = (i % 2) == 1;
                2:       ak = $urandom_range(0, 3) == 0;
                default: ak = $urandom_range(0, 1) == 1;
            endcase
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0,
                 32'($urandom_range(0, 16383)) << 2,
                 ak && m_req);
        end

        step(0, 0, 32'h0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
